// File: rtl/tri_bus_receiver.sv
// ---------------------------------------------------------------------------
// tri_bus_receiver
//
// Purpose:
//    This is the listening end of the shared tri-state data bus. The sender
//    drives bus_data and raises bus_strobe. The receiver captures the word,
//    answers with a registered bus_ack and waits for the strobe to drop
//    (four-phase handshake). Captured words go into a small show-ahead FIFO,
//    and the pipeline drains that FIFO through a pop interface. While an ack
//    is pending the sender must keep bus_data stable. If it does not, a
//    sticky protocol error is raised.
//
// Ports:
//    clk         system clock, every state update happens on posedge
//    reset       asynchronous active-high reset, clears all state
//    bus_data    resolved value of the shared bus (WIDTH bits)
//    bus_strobe  sender asserts while bus_data is valid
//    bus_ack     registered receiver acknowledge
//    rd_en       pop request from the consumer
//    rd_data     head entry of the FIFO, valid while empty=0
//    empty       FIFO holds no entries
//    full        FIFO holds DEPTH entries
//    count       number of entries held (0..DEPTH)
//    proto_err   sticky protocol-violation flag
//    err_clr     synchronous clear of proto_err
// ---------------------------------------------------------------------------
module tri_bus_receiver #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] bus_data,
   input  logic             bus_strobe,
   output logic             bus_ack,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full,
   output logic [AW:0]      count,
   output logic             proto_err,
   input  logic             err_clr
);

   // Handshake states. IDLE waits for a strobe. ACK holds the acknowledge
   // until the sender releases the strobe.
   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } stateT;

   localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

   stateT            state;
   stateT            stateNext;
   logic             acceptWord;
   logic             popWord;
   logic             dataChanged;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wrPtr;
   logic [AW-1:0]    rdPtr;
   logic [AW:0]      countReg;
   logic [AW:0]      countNext;
   logic             emptyReg;
   logic             fullReg;
   logic [WIDTH-1:0] cmpReg;
   logic             protoErrReg;

   // The handshake state lives in this register. bus_ack is decoded only
   // from this register, so no input can reach the ack combinationally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state logic for the handshake. A word is accepted only from IDLE
   // and only while the FIFO is not full. The full flag used here is the
   // registered one, so a pop at full frees space one edge later. This is
   // how backpressure works: the sender keeps its strobe high, and nothing
   // is dropped or overwritten.
   always_comb begin
      stateNext  = state;
      acceptWord = 1'b0;
      case (state)
         IDLE: begin
            if (bus_strobe && !fullReg) begin
               acceptWord = 1'b1;
               stateNext  = ACK;
            end
         end
         ACK: begin
            if (!bus_strobe) begin
               stateNext = IDLE;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Pop is honoured only while something is held. A pop on an empty FIFO
   // is silently ignored. A violation is a change in bus_data while the
   // sender is still strobing in ACK.
   always_comb begin
      popWord     = rd_en && !emptyReg;
      dataChanged = (state == ACK) && bus_strobe && (bus_data != cmpReg);
   end

   // Occupancy bookkeeping. A write and a pop on the same edge cancel out.
   always_comb begin
      countNext = countReg;
      case ({acceptWord, popWord})
         2'b10:   countNext = countReg + 1'b1;
         2'b01:   countNext = countReg - 1'b1;
         default: countNext = countReg;
      endcase
   end

   // Pointers and the registered status flags. The flags are computed from
   // the next count, so after every edge they agree with the pointers.
   // Because DEPTH is a power of two, the pointers wrap on their own.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr    <= '0;
         rdPtr    <= '0;
         countReg <= '0;
         emptyReg <= 1'b1;
         fullReg  <= 1'b0;
      end else begin
         if (acceptWord) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (popWord) begin
            rdPtr <= rdPtr + 1'b1;
         end
         countReg <= countNext;
         emptyReg <= (countNext == '0);
         fullReg  <= (countNext == FullCount);
      end
   end

   // Storage array, written on accepted words. It has no reset: once the
   // pointers are reset, any stale entries are unreachable.
   always_ff @(posedge clk) begin
      if (acceptWord) begin
         mem[wrPtr] <= bus_data;
      end
   end

   // Capture of the accepted word, used later to check that the sender held
   // the bus stable for the whole acknowledge phase.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmpReg <= '0;
      end else if (acceptWord) begin
         cmpReg <= bus_data;
      end
   end

   // Sticky error flag. When a new violation and a clear arrive on the same
   // edge, the violation wins, so the event is never lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         protoErrReg <= 1'b0;
      end else if (dataChanged) begin
         protoErrReg <= 1'b1;
      end else if (err_clr) begin
         protoErrReg <= 1'b0;
      end
   end

   // Output drive. rd_data is the show-ahead head entry read straight from
   // the registered storage.
   always_comb begin
      bus_ack   = (state == ACK);
      rd_data   = mem[rdPtr];
      empty     = emptyReg;
      full      = fullReg;
      count     = countReg;
      proto_err = protoErrReg;
   end

endmodule

// File: doc/tri_bus_receiver.md
Name: tri_bus_receiver

Overview:
- Listening end of the shared 8-bit tri-state data bus; the transmit side is tri-state drivers plus a strobe.
- Captures each bus word using a four-phase strobe/ack handshake and buffers it in a small FIFO.
- The pipeline drains the FIFO with a pop interface.
- Checks sender protocol: data must stay stable while ack is pending, otherwise a sticky error is flagged.

Parameters:
- WIDTH, 8: bus/data width in bits.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- AW, 2: pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- bus_data  input  WIDTH  resolved value of the shared tri-state bus.
- bus_strobe  input  1  sender asserts when bus_data is valid.
- bus_ack  output  1  receiver acknowledge, registered.
- rd_en  input  1  pop request from the consumer.
- rd_data  output  WIDTH  head entry (show-ahead); valid when empty=0.
- empty  output  1  FIFO holds 0 entries.
- full  output  1  FIFO holds DEPTH entries.
- count  output  AW+1  number of entries held (0..DEPTH).
- proto_err  output  1  sticky protocol-violation flag.
- err_clr  input  1  synchronous clear of proto_err.

Behaviour:
- One clock domain. Reset is asynchronous and active-high. Clock port is clk, reset port is reset.
- Reset values: bus_ack=0, empty=1, full=0, count=0, proto_err=0, FSM=IDLE, pointers=0. rd_data after reset is don't-care.
- Reset asserted mid-handshake: immediately returns to IDLE with bus_ack=0 and discards all FIFO contents.
- FSM has two states, IDLE and ACK.
- IDLE, bus_strobe=1 and full=0:
  - write bus_data to mem[wr_ptr] at this edge;
  - wr_ptr+1 (wraps modulo DEPTH);
  - latch bus_data into a compare register;
  - go to ACK; bus_ack reads 1 from this edge on.
  - Strobe-to-ack latency is 1 clock edge.
- IDLE, bus_strobe=1 and full=1: stay in IDLE, bus_ack=0 (backpressure). The sender holds; the word is never lost or overwritten.
- IDLE, bus_strobe=0: no action.
- ACK, bus_strobe=1: hold bus_ack=1. If bus_data differs from the compare register, set proto_err=1.
- ACK, bus_strobe=0: go to IDLE, bus_ack=0 from this edge. A new strobe may be accepted at the next edge. Minimum spacing is 2 edges per word.
- Read side:
  - rd_data = mem[rd_ptr], combinational from registered storage.
  - rd_en=1 and empty=0: rd_ptr+1 (wraps modulo DEPTH).
  - rd_en=1 and empty=1: ignored, no pointer change, no error.
- Same-edge write and pop: count is unchanged, both pointers advance. Writes are only accepted when full=0.
- Pop at full with a strobe pending: the pop happens this edge; the write is accepted at the next edge (full is evaluated from registered state).
- count, empty and full are registered and consistent with the pointers after every edge.
- proto_err is sticky until err_clr=1. If err_clr and a new violation occur on the same edge, set wins.
- No combinational path from any input to bus_ack.

Test Plan:
- Reset mid-ACK: assert reset asynchronously between edges -> bus_ack=0, count=0 and empty=1 immediately, without waiting for a clock edge.
- Single transfer: bus_data=8'hA5, strobe high, then low after ack -> bus_ack high 1 edge after strobe; count=1; rd_data=8'hA5. One pop -> empty=1.
- Fill and backpressure: send 8'h01..8'h04 -> full=1, count=4. A 5th strobe with 8'h05 gets no ack. One pop returns 8'h01 -> next edge the 8'h05 ack rises. Draining then yields 02,03,04,05.
- Wrap-around: push/pop 10 words 8'h10..8'h19 one at a time -> output order exact, count never above 1, pointers wrap without corruption.
- Simultaneous write and pop at count=2 -> count stays 2; popped word is the oldest entry.
- Protocol error: change bus_data from 8'h3C to 8'h3D while in ACK with strobe high -> proto_err=1 and stays set after the handshake. err_clr pulse -> proto_err=0. Pop on empty -> no change.
